// File: rtl/addsub_pipe.sv
// addsub_pipe: chunked add/subtract pipeline with signed saturation and valid/ready flow control
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  logic en;
  assign en = !(out_valid && !out_ready);
  assign in_ready = en;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int HW = WIDTH - k * CHUNK;
    logic [HW-1:0] a_hi, b_hi;
    logic vi, ci, si, v_q, c_q;
    logic [WIDTH-1:0] ri, rn, rd, r_q;
    logic [CHUNK:0] s;
    if (k == 0) begin : g_src
      assign a_hi = a;
      assign b_hi = sub ? ~b : b;
      assign vi = in_valid;
      assign ci = sub;
      assign si = sat;
      assign ri = '0;
    end else begin : g_src
      assign a_hi = g_st[k-1].g_fwd.a_q;
      assign b_hi = g_st[k-1].g_fwd.b_q;
      assign vi = g_st[k-1].v_q;
      assign ci = g_st[k-1].c_q;
      assign si = g_st[k-1].g_fwd.s_q;
      assign ri = g_st[k-1].r_q;
    end
    assign s = {1'b0, a_hi[CHUNK-1:0]} + {1'b0, b_hi[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci};
    assign rn = ri | (WIDTH'(s[CHUNK-1:0]) << (k * CHUNK));
    if (k < STAGES - 1) begin : g_fwd
      logic [HW-CHUNK-1:0] a_q, b_q;
      logic s_q;
      assign rd = rn;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= 1'b0;
        end else if (en) begin
          a_q <= a_hi[HW-1:CHUNK];
          b_q <= b_hi[HW-1:CHUNK];
          s_q <= si;
        end
    end else begin : g_out
      logic o, o_q;
      assign o = (a_hi[CHUNK-1] == b_hi[CHUNK-1]) && (s[CHUNK-1] != a_hi[CHUNK-1]);
      assign rd = (si && o) ? {a_hi[CHUNK-1], {(WIDTH-1){~a_hi[CHUNK-1]}}} : rn;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o_q <= 1'b0;
        else if (en) o_q <= o;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= vi;
        c_q <= s[CHUNK];
        r_q <= rd;
      end
  end
  assign out_valid = g_st[STAGES-1].v_q;
  assign sum = g_st[STAGES-1].r_q;
  assign cout = g_st[STAGES-1].c_q;
  assign ovf = g_st[STAGES-1].g_out.o_q;
endmodule
